// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the ID/EX hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hz_state_t;

  // Conditional-branch major opcode, kept here for the decoder side.
  localparam logic [6:0] BEQ_OP = 7'b1100011;

  // Width of a down-counter that must hold the larger of the two sequence lengths.
  function automatic int cnt_width(input int load_lat, input int flush_depth);
    int m;
    m = (load_lat > flush_depth) ? load_lat : flush_depth;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-side signals seen by the hazard controller.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5
);
  logic              MEMREAD_ID_EX;
  logic [REG_AW-1:0] ARD_ID_EX;
  logic [REG_AW-1:0] ARS1_IF_ID;
  logic [REG_AW-1:0] ARS2_IF_ID;
  logic              USES_RS1;
  logic              USES_RS2;
  logic              BRANCH_EX;
  logic              BEQ_WRONG_PRED;
  logic              EXT_STALL;
  logic              STALL;
  logic              MUX_SEL;
  logic              PCWRITE;
  logic              FLUSH_IF_ID;
  logic              REDIRECT;

  // Pipeline side: supplies decode/EX status, consumes the control outputs.
  modport master (
    output MEMREAD_ID_EX, ARD_ID_EX, ARS1_IF_ID, ARS2_IF_ID,
    output USES_RS1, USES_RS2, BRANCH_EX, BEQ_WRONG_PRED, EXT_STALL,
    input  STALL, MUX_SEL, PCWRITE, FLUSH_IF_ID, REDIRECT
  );

  // Hazard controller side.
  modport slave (
    input  MEMREAD_ID_EX, ARD_ID_EX, ARS1_IF_ID, ARS2_IF_ID,
    input  USES_RS1, USES_RS2, BRANCH_EX, BEQ_WRONG_PRED, EXT_STALL,
    output STALL, MUX_SEL, PCWRITE, FLUSH_IF_ID, REDIRECT
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use match between the ID/EX load and the
// operands of the instruction being decoded. x0 and unused operands never match.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              memread_i,
  input  logic [REG_AW-1:0] ard_i,
  input  logic [REG_AW-1:0] ars1_i,
  input  logic [REG_AW-1:0] ars2_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  output logic              hz_o
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = uses_rs1_i & (ard_i == ars1_i);
  assign rs2_hit = uses_rs2_i & (ard_i == ars2_i);
  assign hz_o    = memread_i & (ard_i != '0) & (rs1_hit | rs2_hit);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: multi-cycle load-use stall and sequenced mispredict flush
// between ID and EX, with a global external freeze.
// Optional STALL_CNT/FLUSH_CNT performance counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic        CLK,
  input  logic        RST,
  hazard_ctrl_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);
  localparam int CW = cnt_width(LOAD_LAT, FLUSH_DEPTH);

  // Where a mispredict or a load-use hazard sends the FSM; a length of 1 is
  // handled entirely by the single RUN cycle.
  localparam hz_state_t      MP_STATE = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
  localparam logic [CW-1:0]  MP_CNT   = (FLUSH_DEPTH > 1) ? CW'(FLUSH_DEPTH - 1) : '0;
  localparam hz_state_t      HZ_STATE = (LOAD_LAT > 1) ? LOAD_STALL : RUN;
  localparam logic [CW-1:0]  HZ_CNT   = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 1) : '0;
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  hz_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hz;
  logic          mp;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .memread_i  (bus.MEMREAD_ID_EX),
    .ard_i      (bus.ARD_ID_EX),
    .ars1_i     (bus.ARS1_IF_ID),
    .ars2_i     (bus.ARS2_IF_ID),
    .uses_rs1_i (bus.USES_RS1),
    .uses_rs2_i (bus.USES_RS2),
    .hz_o       (hz)
  );

  assign mp = bus.BRANCH_EX & bus.BEQ_WRONG_PRED;

  // State and counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: EXT_STALL freezes everything; mispredict outranks a load-use hazard.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.EXT_STALL) begin
      unique case (state_q)
        RUN: begin
          if (mp) begin
            state_d = MP_STATE;
            cnt_d   = MP_CNT;
          end else if (hz) begin
            state_d = HZ_STATE;
            cnt_d   = HZ_CNT;
          end
        end
        LOAD_STALL: begin
          if (mp) begin
            state_d = MP_STATE;
            cnt_d   = MP_CNT;
          end else if (cnt_q == CNT_ONE) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        FLUSH: begin
          if (cnt_q == CNT_ONE) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: all low in reset, freeze pattern on EXT_STALL, otherwise per state.
  always_comb begin
    bus.STALL       = 1'b0;
    bus.MUX_SEL     = 1'b0;
    bus.PCWRITE     = 1'b0;
    bus.FLUSH_IF_ID = 1'b0;
    bus.REDIRECT    = 1'b0;
    if (RST) begin
      bus.PCWRITE = 1'b0;
    end else if (bus.EXT_STALL) begin
      bus.STALL = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mp) begin
            bus.REDIRECT    = 1'b1;
            bus.FLUSH_IF_ID = 1'b1;
            bus.MUX_SEL     = 1'b1;
            bus.PCWRITE     = 1'b1;
          end else if (hz) begin
            bus.STALL   = 1'b1;
            bus.MUX_SEL = 1'b1;
          end else begin
            bus.PCWRITE = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (mp) begin
            bus.REDIRECT    = 1'b1;
            bus.FLUSH_IF_ID = 1'b1;
            bus.MUX_SEL     = 1'b1;
            bus.PCWRITE     = 1'b1;
          end else begin
            bus.STALL   = 1'b1;
            bus.MUX_SEL = 1'b1;
          end
        end
        FLUSH: begin
          bus.FLUSH_IF_ID = 1'b1;
          bus.PCWRITE     = 1'b1;
        end
        default: bus.PCWRITE = 1'b0;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around counters of real stall cycles and redirects.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (bus.STALL && !bus.EXT_STALL) STALL_CNT <= STALL_CNT + 32'd1;
      if (bus.REDIRECT)                FLUSH_CNT <= FLUSH_CNT + 32'd1;
    end
  end
`endif

endmodule
